execute_stage_unit: RTL

Execute stage of the five-stage ARM pipeline. It consumes the decoded control, operands and immediates produced by the ID stage after the ID/EX register. It computes the ALU result, the second operand (Val2), the branch target, and the NZCV status register. Results are registered into EX/MEM outputs that feed the memory stage, and the branch decision goes back to IF.

---
 rtl/execute_stage_unit_pkg.sv | 35 +++
 rtl/execute_stage_unit_val2.sv | 59 +++++
 rtl/execute_stage_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/execute_stage_unit_pkg.sv
// rtl/execute_stage_unit_pkg.sv - shared widths, ALU opcodes and shift codes for the execute stage
package execute_stage_unit_pkg;

  localparam int REGISTER_LEN        = 32;
  localparam int ADDRESS_LEN         = 32;
  localparam int EXECUTE_COMMAND_LEN = 4;

  // ALU opcodes delivered by the decode stage
  typedef enum logic [EXECUTE_COMMAND_LEN-1:0] {
    EXE_MOV = 4'b0001,
    EXE_ADD = 4'b0010,
    EXE_ADC = 4'b0011,
    EXE_SUB = 4'b0100,
    EXE_SBC = 4'b0101,
    EXE_AND = 4'b0110,
    EXE_ORR = 4'b0111,
    EXE_EOR = 4'b1000,
    EXE_MVN = 4'b1001
  } exe_cmd_e;

  // Register shift types, encoded in shift_operand[6:5]
  typedef enum logic [1:0] {
    SHIFT_LSL = 2'b00,
    SHIFT_LSR = 2'b01,
    SHIFT_ASR = 2'b10,
    SHIFT_ROR = 2'b11
  } shift_type_e;

  // Bit positions inside the {N,Z,C,V} status word
  localparam int ST_N = 3;
  localparam int ST_Z = 2;
  localparam int ST_C = 1;
  localparam int ST_V = 0;

endpackage

// File: rtl/execute_stage_unit_val2.sv
// rtl/execute_stage_unit_val2.sv - combinational second-operand (Val2) generator
//   val_rm_in     : register operand Rm
//   shift_operand : 12-bit shifter operand field
//   immediate     : rotated 8-bit immediate form
//   mem_access    : load/store offset form (used only when immediate=0)
//   val2          : resulting second ALU operand
module val2_generator
  import execute_stage_unit_pkg::*;
#(
  parameter int DATA_W = REGISTER_LEN
) (
  input  logic [DATA_W-1:0] val_rm_in,
  input  logic [11:0]       shift_operand,
  input  logic              immediate,
  input  logic              mem_access,
  output logic [DATA_W-1:0] val2
);

  logic [DATA_W-1:0]   imm_zext;
  logic [4:0]          imm_rot;
  logic [2*DATA_W-1:0] imm_dbl;
  logic [DATA_W-1:0]   imm_val;
  logic [DATA_W-1:0]   mem_val;
  logic [4:0]          shamt;
  logic [2*DATA_W-1:0] ror_dbl;
  logic [DATA_W-1:0]   shift_val;
  logic signed [DATA_W-1:0] rm_signed;

  // Rotating a doubled copy right and keeping the low half is a barrel rotate
  // that needs no special case for a zero amount.
  assign imm_zext = {{(DATA_W-8){1'b0}}, shift_operand[7:0]};
  assign imm_rot  = {shift_operand[11:8], 1'b0};
  assign imm_dbl  = {imm_zext, imm_zext} >> imm_rot;
  assign imm_val  = imm_dbl[DATA_W-1:0];

  assign mem_val  = {{(DATA_W-12){shift_operand[11]}}, shift_operand};

  assign shamt     = shift_operand[11:7];
  assign ror_dbl   = {val_rm_in, val_rm_in} >> shamt;
  assign rm_signed = val_rm_in;

  always_comb begin
    shift_val = val_rm_in;
    case (shift_operand[6:5])
      SHIFT_LSL: shift_val = val_rm_in << shamt;
      SHIFT_LSR: shift_val = val_rm_in >> shamt;
      SHIFT_ASR: shift_val = rm_signed >>> shamt;
      SHIFT_ROR: shift_val = ror_dbl[DATA_W-1:0];
      default:   shift_val = val_rm_in;
    endcase
  end

  always_comb begin
    if (immediate)       val2 = imm_val;
    else if (mem_access) val2 = mem_val;
    else                 val2 = shift_val;
  end

endmodule

// File: rtl/execute_stage_unit.sv
// rtl/execute_stage_unit.sv - ARM pipeline execute stage: Val2, ALU, NZCV status, branch target, EX/MEM register
//   clk, rst (sync, active-low), freeze (hold state), flush (bubble into EX/MEM)
//   ID/EX inputs : PC_in, execute_command_in, mem/wb/immediate/branch/status controls,
//                  val_rn_in, val_rm_in, dest_reg_in, signed_immediate_in, shift_operand_in
//   to IF        : branch_taken_out, branch_addr_out (combinational)
//   status_out   : current {N,Z,C,V}
//   EX/MEM       : alu_result, val_rm_out, dest_reg_out, mem_read_out, mem_write_out,
//                  wb_enable_out, PC_out (registered)
module execute_stage_unit
  import execute_stage_unit_pkg::*;
#(
  parameter int DATA_W = REGISTER_LEN,
  parameter int ADDR_W = ADDRESS_LEN
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           freeze,
  input  logic                           flush,
  input  logic [ADDR_W-1:0]              PC_in,
  input  logic [EXECUTE_COMMAND_LEN-1:0] execute_command_in,
  input  logic                           mem_read_in,
  input  logic                           mem_write_in,
  input  logic                           wb_enable_in,
  input  logic                           immediate_in,
  input  logic                           branch_taken_in,
  input  logic                           status_write_enable_in,
  input  logic [DATA_W-1:0]              val_rn_in,
  input  logic [DATA_W-1:0]              val_rm_in,
  input  logic [3:0]                     dest_reg_in,
  input  logic [23:0]                    signed_immediate_in,
  input  logic [11:0]                    shift_operand_in,
  output logic                           branch_taken_out,
  output logic [ADDR_W-1:0]              branch_addr_out,
  output logic [3:0]                     status_out,
  output logic [DATA_W-1:0]              alu_result,
  output logic [DATA_W-1:0]              val_rm_out,
  output logic [3:0]                     dest_reg_out,
  output logic                           mem_read_out,
  output logic                           mem_write_out,
  output logic                           wb_enable_out,
  output logic [ADDR_W-1:0]              PC_out
);

  logic [DATA_W-1:0] val2;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W:0]   sum;
  logic              c_in;
  logic              c_new;
  logic              v_new;
  logic              flags_valid;
  logic [3:0]        status_q;
  logic [ADDR_W-1:0] branch_off;

  val2_generator #(.DATA_W(DATA_W)) u_val2 (
    .val_rm_in     (val_rm_in),
    .shift_operand (shift_operand_in),
    .immediate     (immediate_in),
    .mem_access    (mem_read_in | mem_write_in),
    .val2          (val2)
  );

  // Word offset becomes a byte offset; the add wraps modulo 2^ADDR_W.
  assign branch_off       = {{(ADDR_W-24){signed_immediate_in[23]}}, signed_immediate_in} << 2;
  assign branch_addr_out  = PC_in + branch_off;
  assign branch_taken_out = branch_taken_in;

  assign c_in = status_q[ST_C];

  // Subtraction is done as Rn + ~Val2 + carry-in so the carry out is the
  // ARM "not borrow" directly; SBC uses the stored C as that carry-in.
  always_comb begin
    alu_res     = '0;
    sum         = '0;
    c_new       = status_q[ST_C];
    v_new       = status_q[ST_V];
    flags_valid = 1'b1;
    case (execute_command_in)
      EXE_MOV: alu_res = val2;
      EXE_MVN: alu_res = ~val2;
      EXE_AND: alu_res = val_rn_in & val2;
      EXE_ORR: alu_res = val_rn_in | val2;
      EXE_EOR: alu_res = val_rn_in ^ val2;
      EXE_ADD, EXE_ADC: begin
        sum     = {1'b0, val_rn_in} + {1'b0, val2}
                + {{DATA_W{1'b0}}, (execute_command_in == EXE_ADC) & c_in};
        alu_res = sum[DATA_W-1:0];
        c_new   = sum[DATA_W];
        v_new   = (val_rn_in[DATA_W-1] == val2[DATA_W-1]) &&
                  (alu_res[DATA_W-1] != val_rn_in[DATA_W-1]);
      end
      EXE_SUB, EXE_SBC: begin
        sum     = {1'b0, val_rn_in} + {1'b0, ~val2}
                + {{DATA_W{1'b0}}, (execute_command_in == EXE_SUB) | c_in};
        alu_res = sum[DATA_W-1:0];
        c_new   = sum[DATA_W];
        v_new   = (val_rn_in[DATA_W-1] != val2[DATA_W-1]) &&
                  (alu_res[DATA_W-1] != val_rn_in[DATA_W-1]);
      end
      default: flags_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      status_q      <= 4'b0000;
      alu_result    <= '0;
      val_rm_out    <= '0;
      dest_reg_out  <= '0;
      mem_read_out  <= 1'b0;
      mem_write_out <= 1'b0;
      wb_enable_out <= 1'b0;
      PC_out        <= '0;
    end else if (!freeze) begin
      alu_result <= alu_res;
      val_rm_out <= val_rm_in;
      PC_out     <= PC_in;
      if (flush) begin
        dest_reg_out  <= '0;
        mem_read_out  <= 1'b0;
        mem_write_out <= 1'b0;
        wb_enable_out <= 1'b0;
      end else begin
        dest_reg_out  <= dest_reg_in;
        mem_read_out  <= mem_read_in;
        mem_write_out <= mem_write_in;
        wb_enable_out <= wb_enable_in;
        if (status_write_enable_in && flags_valid)
          status_q <= {alu_res[DATA_W-1], (alu_res == '0), c_new, v_new};
      end
    end
  end

  assign status_out = status_q;

endmodule
